// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ntt_stage_sequencer
// Description : Read/write address sequencer for an in-place radix-4 NTT/INTT.
//               Issues N/4 butterfly-group reads per stage, drains the
//               butterfly pipeline, and replays each read as a write exactly
//               LAT cycles later through a tapped delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_stage_sequencer #(
  parameter int LOG_N    = 9,
  parameter int LAT_NTT  = 7,
  parameter int LAT_INTT = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             rd_en,
  output logic [3:0]       rd_stage,
  output logic [LOG_N-3:0] rd_group,
  output logic             r2_stage,
  output logic             wr_en,
  output logic [3:0]       wr_stage,
  output logic [LOG_N-3:0] wr_group,
  output logic             mode_q,
  output logic             busy,
  output logic             done
);

  localparam int GW      = LOG_N - 2;
  localparam int SW      = 4;
  localparam int NS      = (LOG_N + 1) / 2;
  localparam int DLY     = (LAT_NTT > LAT_INTT) ? LAT_NTT : LAT_INTT;
  localparam int LW      = $clog2(DLY + 1);
  localparam int EW      = 1 + SW + GW;

  localparam logic [SW-1:0] STAGE_LAST = SW'(NS - 1);
  localparam logic [GW-1:0] GROUP_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [GW-1:0]   group_q, group_d;
  logic [LW-1:0]   drain_q, drain_d;
  logic [LW-1:0]   lat_q,   lat_d;
  logic            mode_d;
  logic            start_acc;

  // Delay line: each entry is {valid, stage, group}
  logic [EW-1:0]   dl_q [DLY];
  logic [EW-1:0]   tap;

  assign start_acc = (state_q == S_IDLE) && start;

  // State, counters and latched mode registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      group_q <= '0;
      drain_q <= '0;
      lat_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      group_q <= group_d;
      drain_q <= drain_d;
      lat_q   <= lat_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    group_d = group_q;
    drain_d = drain_q;
    lat_d   = lat_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          lat_d   = mode ? LW'(LAT_INTT) : LW'(LAT_NTT);
          stage_d = '0;
          group_d = '0;
          drain_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        group_d = group_q + 1'b1;
        if (group_q == GROUP_LAST) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == lat_q - 1'b1) begin
          drain_d = '0;
          if (stage_q != STAGE_LAST) begin
            stage_d = stage_q + 1'b1;
            group_d = '0;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-side outputs; indices are forced to zero when no read is issued
  always_comb begin
    rd_en    = (state_q == S_READ);
    rd_stage = rd_en ? stage_q : '0;
    rd_group = rd_en ? group_q : '0;
    busy     = (state_q == S_READ) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
  end

  // Write delay line; cleared on accept so entries left over from a
  // shorter-latency transform cannot reach a longer tap position
  always_ff @(posedge clk) begin
    if (!rst || start_acc) begin
      for (int i = 0; i < DLY; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      dl_q[0] <= {rd_en, rd_stage, rd_group};
      for (int i = 1; i < DLY; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  // Select the delay-line entry that is exactly LAT cycles old
  always_comb begin
    tap = '0;
    for (int i = 0; i < DLY; i++) begin
      if (lat_q == LW'(i + 1)) begin
        tap = dl_q[i];
      end
    end
  end

  // Write-side outputs; indices are forced to zero when no write is issued
  always_comb begin
    wr_en    = tap[EW-1];
    wr_stage = wr_en ? tap[GW +: SW] : '0;
    wr_group = wr_en ? tap[GW-1:0]   : '0;
  end

  // Final radix-2 stage exists only for odd LOG_N
  if ((LOG_N % 2) == 1) begin : g_r2_odd
    assign r2_stage = rd_en && (stage_q == STAGE_LAST);
  end else begin : g_r2_even
    assign r2_stage = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_stage_sequencer
// Description : Self-checking bench for ntt_stage_sequencer (LOG_N=9 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start9, mode9, start8, mode8;

  logic       d9_rd_en, d9_r2, d9_wr_en, d9_mode_q, d9_busy, d9_done;
  logic [3:0] d9_rd_stage, d9_wr_stage;
  logic [6:0] d9_rd_group, d9_wr_group;

  logic       d8_rd_en, d8_r2, d8_wr_en, d8_mode_q, d8_busy, d8_done;
  logic [3:0] d8_rd_stage, d8_wr_stage;
  logic [5:0] d8_rd_group, d8_wr_group;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ntt_stage_sequencer #(.LOG_N(9), .LAT_NTT(7), .LAT_INTT(13)) dut9 (
    .clk(clk), .rst(rst), .start(start9), .mode(mode9),
    .rd_en(d9_rd_en), .rd_stage(d9_rd_stage), .rd_group(d9_rd_group),
    .r2_stage(d9_r2), .wr_en(d9_wr_en), .wr_stage(d9_wr_stage),
    .wr_group(d9_wr_group), .mode_q(d9_mode_q), .busy(d9_busy), .done(d9_done)
  );

  ntt_stage_sequencer #(.LOG_N(8), .LAT_NTT(3), .LAT_INTT(5)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8),
    .rd_en(d8_rd_en), .rd_stage(d8_rd_stage), .rd_group(d8_rd_group),
    .r2_stage(d8_r2), .wr_en(d8_wr_en), .wr_stage(d8_wr_stage),
    .wr_group(d8_wr_group), .mode_q(d8_mode_q), .busy(d8_busy), .done(d8_done)
  );

  // Watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit use8, input bit s, input bit m);
    if (use8) begin start8 = s; mode8 = m; end
    else      begin start9 = s; mode9 = m; end
  endtask

  // Reference: c = cycles since the accepting edge (c<=0 means idle).
  // Stage s occupies period P = N/4 + LAT; its reads fill the first N/4 slots;
  // writes are the same schedule shifted by LAT.
  task automatic check_cycle(input bit use8, input int lgn, input int lat, input int c, input bit m_exp);
    int q, ns, p, cw;
    bit e_rd, e_wr, e_busy, e_done, e_r2;
    int e_rs, e_rg, e_ws, e_wg;
    q  = 1 << (lgn - 2);
    ns = (lgn + 1) / 2;
    p  = q + lat;
    e_rd = 0; e_rs = 0; e_rg = 0;
    if (c >= 1 && (c - 1) / p < ns && (c - 1) % p < q) begin
      e_rd = 1; e_rs = (c - 1) / p; e_rg = (c - 1) % p;
    end
    cw = c - lat;
    e_wr = 0; e_ws = 0; e_wg = 0;
    if (cw >= 1 && (cw - 1) / p < ns && (cw - 1) % p < q) begin
      e_wr = 1; e_ws = (cw - 1) / p; e_wg = (cw - 1) % p;
    end
    e_busy = (c >= 1) && (c <= ns * p);
    e_done = (c == ns * p + 1);
    e_r2   = e_rd && (lgn % 2 == 1) && (e_rs == ns - 1);
    chk("rd_en",    c, use8 ? 32'(d8_rd_en)    : 32'(d9_rd_en),    32'(e_rd));
    chk("rd_stage", c, use8 ? 32'(d8_rd_stage) : 32'(d9_rd_stage), e_rs);
    chk("rd_group", c, use8 ? 32'(d8_rd_group) : 32'(d9_rd_group), e_rg);
    chk("r2_stage", c, use8 ? 32'(d8_r2)       : 32'(d9_r2),       32'(e_r2));
    chk("wr_en",    c, use8 ? 32'(d8_wr_en)    : 32'(d9_wr_en),    32'(e_wr));
    chk("wr_stage", c, use8 ? 32'(d8_wr_stage) : 32'(d9_wr_stage), e_ws);
    chk("wr_group", c, use8 ? 32'(d8_wr_group) : 32'(d9_wr_group), e_wg);
    chk("mode_q",   c, use8 ? 32'(d8_mode_q)   : 32'(d9_mode_q),   32'(m_exp));
    chk("busy",     c, use8 ? 32'(d8_busy)     : 32'(d9_busy),     32'(e_busy));
    chk("done",     c, use8 ? 32'(d8_done)     : 32'(d9_done),     32'(e_done));
  endtask

  task automatic idle(input bit use8, input int lgn, input int n, input bit m_exp);
    for (int k = 0; k < n; k++) begin
      drive(use8, 1'b0, 1'($urandom_range(0, 1)));
      tick();
      check_cycle(use8, lgn, 1, 0, m_exp);
    end
  endtask

  // One transform: start is driven in the current cycle; returns at the
  // idle cycle after done (or after a reset when abort_at > 0).
  task automatic run(input bit use8, input int lgn, input int lat, input bit m,
                     input int noise, input bit hold, input int abort_at,
                     output int first_s1, output int last_wr, output int done_c,
                     output int r2c, output int first_rd_abs, output int done_abs);
    int  q, ns, d, ob_rs;
    bit  ob_rd, ob_wr, ob_done, ob_r2, nz;
    q  = 1 << (lgn - 2);
    ns = (lgn + 1) / 2;
    d  = ns * (q + lat) + 1;
    first_s1 = -1; last_wr = -1; done_c = -1; r2c = 0; first_rd_abs = -1; done_abs = -1;
    drive(use8, 1'b1, m);
    for (int c = 1; c <= d + 1; c++) begin
      tick();
      check_cycle(use8, lgn, lat, c, m);
      ob_rd   = use8 ? d8_rd_en : d9_rd_en;
      ob_rs   = use8 ? int'(d8_rd_stage) : int'(d9_rd_stage);
      ob_wr   = use8 ? d8_wr_en : d9_wr_en;
      ob_done = use8 ? d8_done  : d9_done;
      ob_r2   = use8 ? d8_r2    : d9_r2;
      if (ob_rd && ob_rs == 1 && first_s1 < 0) first_s1 = c;
      if (ob_rd && first_rd_abs < 0) first_rd_abs = cyc;
      if (ob_wr) last_wr = c;
      if (ob_done) begin done_c = c; done_abs = cyc; end
      if (ob_r2) r2c++;
      if (c == abort_at) begin
        rst = 1'b0;
        drive(use8, 1'b1, ~m);
        tick();
        check_cycle(use8, lgn, lat, 0, 1'b0);
        rst = 1'b1;
        drive(use8, 1'b0, 1'b0);
        for (int k = 0; k < lat + 8; k++) begin
          tick();
          check_cycle(use8, lgn, lat, 0, 1'b0);
        end
        return;
      end
      if (c <= d) begin
        if (hold) begin
          drive(use8, 1'b1, 1'($urandom_range(0, 1)));
        end else if (c == d || c == 5) begin
          drive(use8, 1'b1, ~m);
        end else begin
          nz = ($urandom_range(0, 99) < 32'(noise));
          drive(use8, nz, 1'($urandom_range(0, 1)));
        end
      end
    end
  endtask

  initial begin
    int fs1, lw, dc, r2c, fra, da;
    int fs1b, lwb, dcb, r2cb, frab, dab;

    // Reset with start high: start must be ignored
    rst = 1'b0; start9 = 1'b1; mode9 = 1'b1; start8 = 1'b1; mode8 = 1'b1;
    tick(); tick();
    check_cycle(1'b0, 9, 7, 0, 1'b0);
    check_cycle(1'b1, 8, 3, 0, 1'b0);
    rst = 1'b1; start8 = 1'b0;
    idle(1'b0, 9, 1 + $urandom_range(0, 2), 1'b0);

    // NTT, LOG_N=9, start pulses during READ and DONE
    run(1'b0, 9, 7, 1'b0, 30, 1'b0, 0, fs1, lw, dc, r2c, fra, da);
    chk("ntt_stage1_first_rd", 0, fs1, 136);
    chk("ntt_last_wr",         0, lw,  675);
    chk("ntt_done",            0, dc,  676);
    chk("ntt_r2_count",        0, r2c, 128);
    idle(1'b0, 9, 1 + $urandom_range(0, 3), 1'b0);

    // INTT, LOG_N=9
    run(1'b0, 9, 13, 1'b1, 30, 1'b0, 0, fs1, lw, dc, r2c, fra, da);
    chk("intt_stage1_first_rd", 0, fs1, 142);
    chk("intt_last_wr",         0, lw,  705);
    chk("intt_done",            0, dc,  706);
    chk("intt_r2_count",        0, r2c, 128);
    idle(1'b0, 9, 2, 1'b1);

    // Back-to-back with start held: NTT then INTT
    run(1'b0, 9, 7, 1'b0, 0, 1'b1, 0, fs1, lw, dc, r2c, fra, da);
    chk("b2b1_done", 0, dc, 676);
    run(1'b0, 9, 13, 1'b1, 20, 1'b0, 0, fs1b, lwb, dcb, r2cb, frab, dab);
    chk("b2b_gap",   0, frab - da, 2);
    chk("b2b2_done", 0, dcb, 706);
    idle(1'b0, 9, 2, 1'b1);

    // Reset at cycle 50 of stage 0, then a full fresh transform
    run(1'b0, 9, 7, 1'b0, 30, 1'b0, 50, fs1, lw, dc, r2c, fra, da);
    idle(1'b0, 9, 1 + $urandom_range(0, 2), 1'b0);
    run(1'b0, 9, 13, 1'b1, 30, 1'b0, 0, fs1, lw, dc, r2c, fra, da);
    chk("post_rst_first_rd_c", 0, fra - (da - 706), 1);
    chk("post_rst_done",       0, dc, 706);
    idle(1'b0, 9, 2, 1'b1);

    // LOG_N=8: four radix-4 stages, no radix-2 stage
    run(1'b1, 8, 3, 1'b0, 30, 1'b0, 0, fs1, lw, dc, r2c, fra, da);
    chk("n8_ntt_done",     0, dc,  269);
    chk("n8_ntt_r2_count", 0, r2c, 0);
    idle(1'b1, 8, 2, 1'b0);
    run(1'b1, 8, 5, 1'b1, 30, 1'b0, 0, fs1, lw, dc, r2c, fra, da);
    chk("n8_intt_done",     0, dc,  277);
    chk("n8_intt_last_wr",  0, lw,  276);
    chk("n8_intt_r2_count", 0, r2c, 0);
    idle(1'b1, 8, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_stage_sequencer.md
NTT_STAGE_SEQUENCER -- requirements
Module: ntt_stage_sequencer

Interface
REQ-001 SHALL have parameter LOG_N, default 9, log2 of transform size N; legal range 4..12.
REQ-002 SHALL have parameter LAT_NTT, default 7, read-to-write pipeline latency in NTT mode, in cycles; legal range >=1.
REQ-003 SHALL have parameter LAT_INTT, default 13, read-to-write pipeline latency in INTT mode, in cycles; legal range >=1.
REQ-004 SHALL derive GW = LOG_N-2 (group index width) and NS = ceil(LOG_N/2) (stage count); SW = 4 (stage index width).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  request a full transform; sampled only in IDLE.
REQ-008 mode  in  1  0 = NTT, 1 = INTT; sampled with start.
REQ-009 rd_en  out  1  read issue for one butterfly group.
REQ-010 rd_stage  out  SW  stage index of current read.
REQ-011 rd_group  out  GW  group index of current read.
REQ-012 r2_stage  out  1  high with rd_en when LOG_N is odd and rd_stage = NS-1 (final radix-2 stage).
REQ-013 wr_en  out  1  write-back strobe for one group.
REQ-014 wr_stage  out  SW  stage index of current write.
REQ-015 wr_group  out  GW  group index of current write.
REQ-016 mode_q  out  1  latched mode; drives twiddle/butterfly select.
REQ-017 busy  out  1  high from first read through last write.
REQ-018 done  out  1  one-cycle pulse at transform completion.

Function
REQ-019 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-020 IDLE: start=1 -> latch mode into mode_q, load LAT = (mode ? LAT_INTT : LAT_NTT), clear stage and group counters, go to READ; start=0 -> stay.
REQ-021 start SHALL be ignored in READ, DRAIN and DONE; mode_q SHALL hold through the whole transform.
REQ-022 READ: rd_en=1 every cycle; rd_group increments 0..N/4-1 with rd_stage constant; after group N/4-1 go to DRAIN.
REQ-023 DRAIN: rd_en=0 for exactly LAT cycles; after them, if stage < NS-1 then increment stage, clear group, go to READ; otherwise go to DONE.
REQ-024 Consequence: first read of stage s+1 occurs LAT+1 cycles after the last read of stage s.
REQ-025 Write pipeline: a delay line of max(LAT_NTT,LAT_INTT) entries carrying {valid, stage, group}, tapped at LAT.
REQ-026 wr_en/wr_stage/wr_group SHALL equal rd_en/rd_stage/rd_group delayed by exactly LAT cycles; the write and the read of the same stage never overlap.
REQ-027 busy SHALL be high in READ and DRAIN; low in IDLE and DONE.
REQ-028 DONE: done=1 for one cycle, busy=0, then IDLE; start in DONE is not accepted.
REQ-029 Group counter wraps at N/4 with no overflow into stage; stage counter never exceeds NS-1.
REQ-030 When rd_en/wr_en are low, their index outputs SHALL be 0.

Reset
REQ-031 rst=0 at a rising edge SHALL force IDLE and clear all counters, the delay line and mode_q; all outputs 0 the following cycle.
REQ-032 Reset asserted mid-transform SHALL discard in-flight writes: no wr_en after reset, even for reads issued before it.
REQ-033 start asserted in the same cycle as rst=0 SHALL be ignored.

Verification
REQ-034 LOG_N=9, mode=0, start at cycle 0 -> rd_en cycles 1..128 (stage 0), wr_en 8..135, stage 1 reads from 136, last read 668, last write 675, done at 676.
REQ-035 LOG_N=9, mode=1 -> stage period 141, stage 4 reads 565..692, last write 705, done at 706, mode_q=1 throughout.
REQ-036 LOG_N=9 -> r2_stage high only during stage 4 reads; LOG_N=8 -> NS=4, r2_stage never high.
REQ-037 start pulsed during READ and in DONE -> no restart; rd_group sequence unchanged.
REQ-038 rst=0 at cycle 50 of stage 0 -> next cycle all outputs 0, no wr_en afterwards; new start runs a complete transform from stage 0.
REQ-039 Back-to-back: start held high continuously -> second transform's first read exactly 2 cycles after done (DONE->IDLE->READ).
